// File: rtl/sys_skew_feeder_if.sv
// sys_skew_feeder_if
// Bundles the SRAM load bus and the skewed feed bus of sys_skew_feeder.
//   wr_valid/wr_ready/wr_data : load word handshake (producer -> feeder)
//   feed_valid                : per-lane valid, bit i = lane i
//   data_2_sys/weight_2_sys   : lane i at [i*DATA_W +: DATA_W]
// Modports: master = load producer / array side, slave = the feeder.
interface sys_skew_feeder_if #(
  parameter int DATA_W  = 16,
  parameter int ARRAY_N = 4
);
  logic                      wr_valid;
  logic                      wr_ready;
  logic [DATA_W-1:0]         wr_data;
  logic [ARRAY_N-1:0]        feed_valid;
  logic [ARRAY_N*DATA_W-1:0] data_2_sys;
  logic [ARRAY_N*DATA_W-1:0] weight_2_sys;

  modport master (
    output wr_valid, wr_data,
    input  wr_ready, feed_valid, data_2_sys, weight_2_sys
  );

  modport slave (
    input  wr_valid, wr_data,
    output wr_ready, feed_valid, data_2_sys, weight_2_sys
  );
endinterface

// File: rtl/sys_skew_feeder.sv
// sys_skew_feeder
// Serially loads ARRAY_N data lanes and ARRAY_N weight lanes (DEPTH words each)
// from the SRAM read bus, then feeds an ARRAY_N x ARRAY_N systolic array with
// diagonal skew: lane i starts i cycles after lane 0, zero padded outside its
// window.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   load_start     pulse, starts a load (IDLE only)
//   compute_start  pulse, starts a feed (LOADED only)
//   abort          synchronous abort, highest priority, returns to IDLE
//   bus            sys_skew_feeder_if.slave: load handshake + feed outputs
//   load_done      level, all 2*ARRAY_N*DEPTH words stored (LOADED)
//   feed_done      one-cycle pulse in the cycle after the last feed beat
//   busy           state != IDLE
//   word_cnt       words accepted in the current load
//   state_dbg      raw FSM state for observation
// Handshake: a load word transfers on a rising edge where wr_valid && wr_ready
// are both high; wr_ready is high exactly while in LOAD (combinational from the
// state register) and never depends on wr_valid.
module sys_skew_feeder #(
  parameter int DATA_W  = 16,
  parameter int ARRAY_N = 4,
  parameter int DEPTH   = 4,
  localparam int CNT_W  = $clog2(2*ARRAY_N*DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             compute_start,
  input  logic             abort,
  sys_skew_feeder_if.slave bus,
  output logic             load_done,
  output logic             feed_done,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt,
  output logic [1:0]       state_dbg
);

  localparam int TOTAL  = 2*ARRAY_N*DEPTH;
  localparam int AW     = $clog2(TOTAL);
  localparam int LAST_T = DEPTH + ARRAY_N - 2;
  // Counter must also hold LAST_T+1, the drain cycle after the final beat.
  localparam int T_W    = $clog2(DEPTH + ARRAY_N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    LOADED = 2'd2,
    FEED   = 2'd3
  } state_t;

  state_t                    state;
  logic [T_W-1:0]            t_cnt;
  logic [ARRAY_N-1:0]        valid_q;
  logic [ARRAY_N*DATA_W-1:0] data_q;
  logic [ARRAY_N*DATA_W-1:0] weight_q;
  logic                      feed_done_q;

  logic [ARRAY_N-1:0]        nxt_valid;
  logic [ARRAY_N*DATA_W-1:0] nxt_data;
  logic [ARRAY_N*DATA_W-1:0] nxt_weight;

  // Flat word store: beat k lands at index k, which is buffer k/DEPTH,
  // slot k%DEPTH. Data lanes occupy the first half, weight lanes the second.
  logic [DATA_W-1:0] buf_mem [TOTAL];

  logic beat;
  assign beat = (state == LOAD) && bus.wr_valid;

  assign bus.wr_ready     = (state == LOAD);
  assign bus.feed_valid   = valid_q;
  assign bus.data_2_sys   = data_q;
  assign bus.weight_2_sys = weight_q;
  assign load_done        = (state == LOADED);
  assign busy             = (state != IDLE);
  assign feed_done        = feed_done_q;
  assign state_dbg        = state;

  // Buffer has no reset; every slot is rewritten by each load.
  always_ff @(posedge clk) begin
    if (beat && !abort) begin
      buf_mem[word_cnt[AW-1:0]] <= bus.wr_data;
    end
  end

  // Skewed lane selection for the beat at t_cnt. Lane i is inside its window
  // when i <= t < i+DEPTH and then reads slot t-i.
  always_comb begin
    nxt_valid  = '0;
    nxt_data   = '0;
    nxt_weight = '0;
    for (int i = 0; i < ARRAY_N; i++) begin
      if ((int'(t_cnt) >= i) && (int'(t_cnt) < i + DEPTH)) begin
        nxt_valid[i] = 1'b1;
        nxt_data[i*DATA_W +: DATA_W] =
          buf_mem[AW'(i*DEPTH + int'(t_cnt) - i)];
        nxt_weight[i*DATA_W +: DATA_W] =
          buf_mem[AW'((ARRAY_N + i)*DEPTH + int'(t_cnt) - i)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      word_cnt    <= '0;
      t_cnt       <= '0;
      valid_q     <= '0;
      data_q      <= '0;
      weight_q    <= '0;
      feed_done_q <= 1'b0;
    end else begin
      feed_done_q <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        word_cnt <= '0;
        t_cnt    <= '0;
        valid_q  <= '0;
        data_q   <= '0;
        weight_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (load_start) begin
              state    <= LOAD;
              word_cnt <= '0;
            end
          end
          LOAD: begin
            if (beat) begin
              word_cnt <= word_cnt + 1'b1;
              if (word_cnt == CNT_W'(TOTAL-1)) begin
                state <= LOADED;
              end
            end
          end
          LOADED: begin
            if (compute_start) begin
              state <= FEED;
              t_cnt <= '0;
            end
          end
          FEED: begin
            // The extra count after LAST_T clears the buses while raising
            // feed_done, so the final beat stays visible for a full cycle.
            if (t_cnt == T_W'(LAST_T + 1)) begin
              state       <= IDLE;
              t_cnt       <= '0;
              valid_q     <= '0;
              data_q      <= '0;
              weight_q    <= '0;
              feed_done_q <= 1'b1;
            end else begin
              valid_q  <= nxt_valid;
              data_q   <= nxt_data;
              weight_q <= nxt_weight;
              t_cnt    <= t_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sys_skew_feeder.sv
module tb_sys_skew_feeder;
  localparam int DW    = 16;
  localparam int N     = 4;
  localparam int D     = 4;
  localparam int TOTAL = 2*N*D;
  localparam int BEATS = D + N - 1;
  localparam int CW    = $clog2(TOTAL+1);
  localparam int BW    = N + 2*N*DW;
  localparam int CW1   = $clog2(3);

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: N=4, D=4
  logic ls0 = 1'b0, cs0 = 1'b0, ab0 = 1'b0;
  logic ld0, fd0, busy0;
  logic [CW-1:0] wc0;
  logic [1:0] st0;
  sys_skew_feeder_if #(.DATA_W(DW), .ARRAY_N(N)) bus0 ();
  sys_skew_feeder #(.DATA_W(DW), .ARRAY_N(N), .DEPTH(D)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .load_start(ls0), .compute_start(cs0),
    .abort(ab0), .bus(bus0), .load_done(ld0), .feed_done(fd0),
    .busy(busy0), .word_cnt(wc0), .state_dbg(st0)
  );

  // DUT 1: N=1, D=1
  logic ls1 = 1'b0, cs1 = 1'b0, ab1 = 1'b0;
  logic ld1, fd1, busy1;
  logic [CW1-1:0] wc1;
  logic [1:0] st1;
  sys_skew_feeder_if #(.DATA_W(DW), .ARRAY_N(1)) bus1 ();
  sys_skew_feeder #(.DATA_W(DW), .ARRAY_N(1), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load_start(ls1), .compute_start(cs1),
    .abort(ab1), .bus(bus1), .load_done(ld1), .feed_done(fd1),
    .busy(busy1), .word_cnt(wc1), .state_dbg(st1)
  );

  // scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] words [TOTAL];
  logic [BW-1:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: each lane is a stream of i bubbles, its DEPTH words, then
  // bubbles; the array sees one element of every stream per beat.
  task automatic build_expected();
    logic [2*DW:0] lane_q [N][$];
    logic [BW-1:0] e;
    logic [N-1:0] v;
    logic [N*DW-1:0] dd, ww;
    logic [2*DW:0] el;
    for (int i = 0; i < N; i++) begin
      lane_q[i].delete();
      for (int b = 0; b < i; b++) lane_q[i].push_back('0);
      for (int s = 0; s < D; s++)
        lane_q[i].push_back({1'b1, words[i*D + s], words[(N+i)*D + s]});
      while (lane_q[i].size() < BEATS) lane_q[i].push_back('0);
    end
    exp_q.delete();
    for (int t = 0; t < BEATS; t++) begin
      v = '0; dd = '0; ww = '0;
      for (int i = 0; i < N; i++) begin
        el = lane_q[i].pop_front();
        v[i] = el[2*DW];
        dd[i*DW +: DW] = el[2*DW-1:DW];
        ww[i*DW +: DW] = el[DW-1:0];
      end
      e = {v, dd, ww};
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    bus0.wr_valid = 1'b0; bus0.wr_data = '0;
    bus1.wr_valid = 1'b0; bus1.wr_data = '0;
    rst_n = 1'b0;
    step(); step();
    n_tests++;
    if ({bus0.feed_valid, bus0.data_2_sys, bus0.weight_2_sys} !== '0) begin
      n_fail++; $display("FAIL reset_feed0: got %0h want 0",
        {bus0.feed_valid, bus0.data_2_sys, bus0.weight_2_sys});
    end
    n_tests++;
    if ({ld0, fd0, busy0, bus0.wr_ready, wc0} !== '0) begin
      n_fail++; $display("FAIL reset_ctrl0: got %0h want 0",
        {ld0, fd0, busy0, bus0.wr_ready, wc0});
    end
    n_tests++;
    if ({bus1.feed_valid, bus1.data_2_sys, bus1.weight_2_sys, ld1, fd1, busy1, wc1} !== '0) begin
      n_fail++; $display("FAIL reset_dut1: got %0h want 0",
        {bus1.feed_valid, bus1.data_2_sys, bus1.weight_2_sys, ld1, fd1, busy1, wc1});
    end
    rst_n = 1'b1;
    step();
    // reset in the middle of a load
    ls0 = 1'b1; step(); ls0 = 1'b0;
    bus0.wr_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus0.wr_data = DW'($urandom_range(0, 65535));
      step();
    end
    bus0.wr_valid = 1'b0;
    n_tests++;
    if (wc0 !== CW'(5)) begin
      n_fail++; $display("FAIL midload_cnt: got %0d want 5", wc0);
    end
    rst_n = 1'b0;
    #2;
    n_tests++;
    if ({busy0, wc0, ld0, fd0, bus0.wr_ready, bus0.feed_valid} !== '0) begin
      n_fail++; $display("FAIL midload_reset: got %0h want 0",
        {busy0, wc0, ld0, fd0, bus0.wr_ready, bus0.feed_valid});
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load(input bit seq, input bit toggle);
    int idx, cyc;
    bit v;
    for (int k = 0; k < TOTAL; k++)
      words[k] = seq ? DW'(k + 1) : DW'($urandom_range(0, 65535));
    ls0 = 1'b1; step(); ls0 = 1'b0;
    idx = 0; cyc = 0;
    while (idx < TOTAL && cyc < 400) begin
      n_tests++;
      if (bus0.wr_ready !== 1'b1) begin
        n_fail++; $display("FAIL load_ready: got %0b want 1 at word %0d", bus0.wr_ready, idx);
      end
      v = toggle ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      bus0.wr_valid = v;
      bus0.wr_data = v ? words[idx] : DW'($urandom_range(0, 65535));
      step();
      if (v) idx++;
      cyc++;
      n_tests++;
      if (wc0 !== CW'(idx)) begin
        n_fail++; $display("FAIL load_cnt: got %0d want %0d", wc0, idx);
      end
      n_tests++;
      if (ld0 !== (idx == TOTAL)) begin
        n_fail++; $display("FAIL load_done: got %0b want %0b at word %0d", ld0, idx == TOTAL, idx);
      end
    end
    n_tests++;
    if (idx != TOTAL) begin
      n_fail++; $display("FAIL load_timeout: got %0d words want %0d", idx, TOTAL);
    end
    // extra offered words must not be accepted
    bus0.wr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus0.wr_data = DW'($urandom_range(0, 65535));
      step();
      n_tests++;
      if ({bus0.wr_ready, ld0, wc0} !== {1'b0, 1'b1, CW'(TOTAL)}) begin
        n_fail++; $display("FAIL loaded_hold: got ready=%0b done=%0b cnt=%0d want 0 1 %0d",
          bus0.wr_ready, ld0, wc0, TOTAL);
      end
    end
    bus0.wr_valid = 1'b0;
  endtask

  task automatic test_feed();
    logic [BW-1:0] e;
    build_expected();
    cs0 = 1'b1; step(); cs0 = 1'b0;
    n_tests++;
    if ({bus0.feed_valid, ld0, busy0} !== {N'(0), 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL feed_enter: got valid=%0b done=%0b busy=%0b want 0 0 1",
        bus0.feed_valid, ld0, busy0);
    end
    for (int t = 0; t < BEATS; t++) begin
      step();
      e = exp_q.pop_front();
      n_tests++;
      if ({bus0.feed_valid, bus0.data_2_sys, bus0.weight_2_sys} !== e) begin
        n_fail++; $display("FAIL feed_beat%0d: got %0h want %0h", t,
          {bus0.feed_valid, bus0.data_2_sys, bus0.weight_2_sys}, e);
      end
      n_tests++;
      if ({fd0, busy0} !== 2'b01) begin
        n_fail++; $display("FAIL feed_flags%0d: got done=%0b busy=%0b want 0 1", t, fd0, busy0);
      end
    end
    step();
    n_tests++;
    if ({fd0, busy0, bus0.feed_valid, bus0.data_2_sys, bus0.weight_2_sys} !== {1'b1, (BW+1)'(0)}) begin
      n_fail++; $display("FAIL feed_done: got done=%0b busy=%0b bus=%0h want 1 0 0",
        fd0, busy0, {bus0.feed_valid, bus0.data_2_sys, bus0.weight_2_sys});
    end
    step();
    n_tests++;
    if ({fd0, busy0} !== 2'b00) begin
      n_fail++; $display("FAIL feed_done_pulse: got done=%0b busy=%0b want 0 0", fd0, busy0);
    end
  endtask

  task automatic test_ignored();
    cs0 = 1'b1; step(); cs0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if ({busy0, bus0.feed_valid, fd0, bus0.wr_ready} !== '0) begin
        n_fail++; $display("FAIL idle_compute: got %0h want 0",
          {busy0, bus0.feed_valid, fd0, bus0.wr_ready});
      end
      step();
    end
    ls0 = 1'b1; ab0 = 1'b1; step(); ls0 = 1'b0; ab0 = 1'b0;
    n_tests++;
    if ({busy0, bus0.wr_ready} !== 2'b00) begin
      n_fail++; $display("FAIL abort_vs_load: got busy=%0b ready=%0b want 0 0", busy0, bus0.wr_ready);
    end
    test_load(1'b0, 1'b0);
    ls0 = 1'b1; step(); ls0 = 1'b0;
    n_tests++;
    if ({ld0, bus0.wr_ready, wc0, bus0.feed_valid} !== {1'b1, 1'b0, CW'(TOTAL), N'(0)}) begin
      n_fail++; $display("FAIL loaded_load_start: got done=%0b ready=%0b cnt=%0d want 1 0 %0d",
        ld0, bus0.wr_ready, wc0, TOTAL);
    end
    test_feed();
  endtask

  task automatic test_abort();
    logic [BW-1:0] e;
    test_load(1'b0, 1'b0);
    build_expected();
    cs0 = 1'b1; step(); cs0 = 1'b0;
    for (int t = 0; t < 3; t++) begin
      step();
      e = exp_q.pop_front();
      n_tests++;
      if ({bus0.feed_valid, bus0.data_2_sys, bus0.weight_2_sys} !== e) begin
        n_fail++; $display("FAIL abort_pre_beat%0d: got %0h want %0h", t,
          {bus0.feed_valid, bus0.data_2_sys, bus0.weight_2_sys}, e);
      end
    end
    ab0 = 1'b1; step(); ab0 = 1'b0;
    n_tests++;
    if ({bus0.feed_valid, bus0.data_2_sys, bus0.weight_2_sys, busy0, wc0, ld0, fd0} !== '0) begin
      n_fail++; $display("FAIL abort_clear: got %0h want 0",
        {bus0.feed_valid, bus0.data_2_sys, bus0.weight_2_sys, busy0, wc0, ld0, fd0});
    end
    for (int k = 0; k < 6; k++) begin
      step();
      n_tests++;
      if ({fd0, busy0, bus0.feed_valid} !== '0) begin
        n_fail++; $display("FAIL abort_no_done: got done=%0b busy=%0b valid=%0b want 0",
          fd0, busy0, bus0.feed_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 2; j++) begin
      test_load(1'b0, 1'b0);
      test_feed();
    end
  endtask

  task automatic test_single_lane();
    logic [DW-1:0] dw, ww;
    for (int j = 0; j < 2; j++) begin
      dw = (j == 0) ? DW'(5) : DW'($urandom_range(0, 65535));
      ww = (j == 0) ? DW'(9) : DW'($urandom_range(0, 65535));
      ls1 = 1'b1; step(); ls1 = 1'b0;
      bus1.wr_valid = 1'b1;
      bus1.wr_data = dw; step();
      bus1.wr_data = ww; step();
      bus1.wr_valid = 1'b0;
      n_tests++;
      if ({ld1, wc1, bus1.wr_ready} !== {1'b1, CW1'(2), 1'b0}) begin
        n_fail++; $display("FAIL n1_loaded: got done=%0b cnt=%0d ready=%0b want 1 2 0",
          ld1, wc1, bus1.wr_ready);
      end
      cs1 = 1'b1; step(); cs1 = 1'b0;
      step();
      n_tests++;
      if ({bus1.feed_valid, bus1.data_2_sys, bus1.weight_2_sys, fd1} !== {1'b1, dw, ww, 1'b0}) begin
        n_fail++; $display("FAIL n1_beat: got valid=%0b data=%0d weight=%0d done=%0b want 1 %0d %0d 0",
          bus1.feed_valid, bus1.data_2_sys, bus1.weight_2_sys, fd1, dw, ww);
      end
      step();
      n_tests++;
      if ({fd1, busy1, bus1.feed_valid, bus1.data_2_sys, bus1.weight_2_sys} !== {1'b1, (2+2*DW)'(0)}) begin
        n_fail++; $display("FAIL n1_done: got done=%0b busy=%0b valid=%0b want 1 0 0",
          fd1, busy1, bus1.feed_valid);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_load(1'b1, 1'b1);
    test_feed();
    test_ignored();
    test_abort();
    test_back_to_back();
    test_single_lane();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
